// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry in-order buffer of {pc, instr} between fetch and decode.
// A push is visible one edge later; if_stall rises when full and is registered-only; flush empties everything.
module if_id_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     if_stall,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pc8,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  entry_t        head;

  always_comb begin
    if_stall  = (count_q == FULL);
    out_valid = (count_q != '0);
    push      = in_valid & ~if_stall & ~flush;
    pop       = out_valid & out_ready & ~flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Stale storage is masked whenever the queue is empty.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_pc    = out_valid ? head.pc    : 32'h0;
    out_instr = out_valid ? head.instr : NOP_WORD;
    out_pc8   = out_pc + 32'd8;
    count     = count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic against a queue-based model.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        if_stall;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pc8;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  pair_t       exp_q[$];
  logic [31:0] cur_pc;
  logic [31:0] cur_instr;

  if_id_queue #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .if_stall(if_stall), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
    .out_pc8(out_pc8), .out_instr(out_instr), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare outputs against the model mid-cycle, then retire what the coming edge consumes.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_pc", out_pc, exp_q[0].pc);
      chk("out_instr", out_instr, exp_q[0].instr);
      chk("out_pc8", out_pc8, exp_q[0].pc + 32'd8);
    end else begin
      chk("out_valid_empty", 32'(out_valid), 32'd0);
      chk("out_pc_empty", out_pc, 32'd0);
      chk("out_instr_empty", out_instr, NOP);
      chk("out_pc8_empty", out_pc8, 32'd8);
    end
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("if_stall", 32'(if_stall), 32'(exp_q.size() == DEPTH));
    if (!reset || flush) exp_q.delete();
    else if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  // Fetch side: offer the current pair; an unaccepted pair is re-offered next cycle.
  task automatic step(input bit v, input bit rdy, input bit fl);
    bit acc;
    in_valid  = v;
    in_pc     = v ? cur_pc : $urandom;
    in_instr  = v ? cur_instr : $urandom;
    out_ready = rdy;
    flush     = fl;
    acc = v && !fl && (exp_q.size() < DEPTH);
    @(negedge clk);
    #1;
    if (acc && reset) begin
      exp_q.push_back('{pc: cur_pc, instr: cur_instr});
      cur_pc    = cur_pc + 32'd4;
      cur_instr = $urandom;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h0000_3000;
    in_instr  = 32'h3C01_0001;
    out_ready = 1'b0;
    flush     = 1'b0;
    cur_pc    = 32'h0000_3000;
    cur_instr = 32'h3C01_0001;

    // Reset held with a live offer: nothing may enter.
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pc8", out_pc8, 32'd8);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // First push after release, then fill to full and hold 0x3010 under stall.
    step(1, 0, 0);
    chk("first_pc", out_pc, 32'h0000_3000);
    chk("first_pc8", out_pc8, 32'h0000_3008);
    chk("first_instr", out_instr, 32'h3C01_0001);
    repeat (3) step(1, 0, 0);
    chk("full_stall", 32'(if_stall), 32'd1);
    repeat (2) step(1, 0, 0);
    chk("held_pc", cur_pc, 32'h0000_3010);
    step(1, 1, 0);
    chk("stall_fell", 32'(if_stall), 32'd0);
    step(1, 1, 0);
    repeat (5) step(0, 1, 0);

    // Streaming, then alternating ready across the wrap boundary.
    repeat (20) step(1, 1, 0);
    for (int i = 0; i < 10; i++) step(1, bit'(i % 2), 0);
    repeat (6) step(0, 1, 0);

    // Flush drops the queue and the pair offered alongside it.
    step(0, 0, 1);
    cur_pc = 32'h0000_3000;
    repeat (3) step(1, 0, 0);
    cur_pc = 32'h0000_300C;
    step(1, 1, 1);
    chk("flush_count", 32'(count), 32'd0);
    cur_pc = 32'h0000_4000;
    step(1, 0, 0);
    chk("redirect_pc", out_pc, 32'h0000_4000);
    step(0, 1, 0);

    // Random traffic with occasional redirects, including one near the top of the address space.
    for (int i = 0; i < 400; i++) begin
      bit fl;
      fl = ($urandom_range(0, 24) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, fl);
      if (fl) cur_pc = (i < 200) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
    end

    // Asynchronous reset between edges with three entries queued.
    step(0, 0, 1);
    repeat (3) step(1, 0, 0);
    chk("pre_arst_count", 32'(count), 32'd3);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_instr", out_instr, NOP);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cur_pc = 32'h0000_5000;
    step(1, 0, 0);
    chk("post_arst_pc", out_pc, 32'h0000_5000);
    repeat (3) step(0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction fetch queue that sits between the fetch unit and the decode stage of the five-stage MIPS pipeline. Each cycle it captures the fetched `{PC, instruction}` pair and holds up to DEPTH pairs in order. It presents the oldest pair to decode and back-pressures fetch through a stall output that drives the fetch unit's PC hold enable. A flush input discards every queued instruction on a branch or jump redirect.

## Interface

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16
- NOP_WORD, 32'h0000_0000, instruction word presented when the queue is empty (`sll $0,$0,0`)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, release is sampled on clk
- in_valid  input  1  fetch unit offers a pair this cycle
- in_pc  input  32  PC of the offered instruction
- in_instr  input  32  offered instruction word
- if_stall  output  1  1 when the queue is full; drives the fetch unit's PC hold enable so PC holds
- flush  input  1  redirect; discard all entries and the pair offered this cycle
- out_valid  output  1  head entry valid
- out_pc  output  32  PC of the head entry
- out_pc8  output  32  out_pc + 8, the link value for jal/jalr
- out_instr  output  32  head instruction; NOP_WORD when out_valid=0
- out_ready  input  1  decode consumes the head this cycle; 0 means decode is stalled
- count  output  log2(DEPTH)+1  number of occupied entries

## Operation

- Storage: DEPTH-entry circular buffer of {pc[31:0], instr[31:0]}. Write and read pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is held in `count`.
- push = in_valid & ~if_stall & ~flush.
- pop = out_valid & out_ready & ~flush.
- if_stall = (count == DEPTH). The signal depends only on registered state, so there is no combinational path from out_ready.
- out_valid = (count != 0).
- out_pc and out_instr come from the entry at the read pointer. When empty, out_pc = 0, out_instr = NOP_WORD and out_pc8 = 8.
- Each edge:
  - push writes the entry at the write pointer and advances the write pointer.
  - pop advances the read pointer.
  - count += push − pop.
- Simultaneous push and pop: both occur and count is unchanged. When full, push is blocked (if_stall=1) even if a pop occurs that cycle.
- Flush has priority over everything. On the next edge both pointers and count return to 0. The pair offered that cycle is dropped. Any pop that cycle does not happen and decode must not latch the head.
- Reset (reset=0): pointers and count go to 0 asynchronously. Outputs are then if_stall=0, out_valid=0, out_pc=0, out_pc8=8, out_instr=NOP_WORD, count=0.
- Reset asserted mid-operation discards all entries at once. Storage contents need not be cleared.
- out_pc8 is a 32-bit add with carry discarded (wraps modulo 2^32).
- in_pc and in_instr are ignored when in_valid=0.

## Timing

- Latency: a pair pushed at edge N appears at the outputs after edge N, provided it is at the head. There is no same-cycle bypass from input to output.
- Throughput: one push and one pop per cycle in steady state.
- if_stall rises in the cycle after the push that fills the queue. It falls in the cycle after the first pop from a full queue.
- The fetch unit holds PC while if_stall=1 and re-offers the same pair. No pair is lost or duplicated.
- Flush at edge N: the outputs after edge N show the empty state. The first post-redirect pair offered in cycle N+1 is pushed at edge N+1 and is visible after edge N+1.
- Reset release: the first push can occur at the first rising edge with reset=1.

## Test plan

- Reset: hold reset=0 for 3 cycles with in_valid=1 → count=0, out_valid=0, out_instr=0, out_pc8=8, if_stall=0 throughout. Then release reset, push pc=0x3000 instr=0x3C010001 → after that edge out_pc=0x3000, out_pc8=0x3008, out_instr=0x3C010001.
- Fill and stall: out_ready=0, push pc 0x3000, 0x3004, 0x3008, 0x300C → count=4 and if_stall=1. A fifth offer of 0x3010 is held. Set out_ready=1 → 0x3000 pops, and 0x3010 is accepted one edge after if_stall falls. Pops then yield 0x3004, 0x3008, 0x300C, 0x3010 in order.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with pc incrementing by 4 → count stays at 1 after the first edge, if_stall=0, and each out_pc equals the pc pushed one edge earlier.
- Wrap-around: 10 push/pop cycles with alternating out_ready → out_pc sequence is strictly increasing by 4 across the DEPTH boundary.
- Flush: queue holding 0x3000..0x3008, assert flush with in_valid=1 pc=0x300C and out_ready=1 → next cycle count=0, out_valid=0, and 0x300C is never output. Then push 0x4000 → out_pc=0x4000.
- Asynchronous reset mid-stream: with count=3, drop reset between clock edges → count=0 and out_valid=0 before the next rising edge.
